sc_gt_filter: RTL

SC_GT_FILTER -- requirements
Module: sc_gt_filter

---
 rtl/sc_gt_filter_pkg.sv | 16 +
 rtl/sc_gt_filter_sat.sv | 20 ++
 rtl/sc_gt_filter.sv | 117 +++++++++++
 3 files changed

// File: rtl/sc_gt_filter_pkg.sv
// Shared types and defaults for the greater-than debounce filter.
// Holds the FSM state encoding and the default parameter values.
package sc_gt_filter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ALARM   = 2'd2,
    RELEASE = 2'd3
  } gtState_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COUNT_WIDTH_DEF     = 3;
  localparam int EVENT_WIDTH_DEF     = 8;

endpackage

// File: rtl/sc_gt_filter_sat.sv
// sc_sat_counter: registered up-counter that holds at all-ones.
// Ports: clock, reset (async high), inc (count request), value.
module sc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_gt_filter.sv
// Debounces a greater-than flag into a latched, acknowledged alarm.
// Ports: clock, async reset, gt/enable/ack in; alarm, count, events, state out.
module sc_gt_filter
  import sc_gt_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF,
  parameter int EVENT_WIDTH     = EVENT_WIDTH_DEF
) (
  input  logic                   SC_GT_FILTER_CLOCK_50,
  input  logic                   SC_GT_FILTER_RESET_InHigh,
  input  logic                   SC_GT_FILTER_greaterthan_In,
  input  logic                   SC_GT_FILTER_enable_In,
  input  logic                   SC_GT_FILTER_ack_In,
  output logic                   SC_GT_FILTER_alarm_Out,
  output logic [COUNT_WIDTH-1:0] SC_GT_FILTER_count_OutBUS,
  output logic [EVENT_WIDTH-1:0] SC_GT_FILTER_events_OutBUS,
  output logic [1:0]             SC_GT_FILTER_state_OutBUS
);

  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic clk;
  logic rst;
  logic gt;
  logic en;
  logic ack;

  assign clk = SC_GT_FILTER_CLOCK_50;
  assign rst = SC_GT_FILTER_RESET_InHigh;
  assign gt  = SC_GT_FILTER_greaterthan_In;
  assign en  = SC_GT_FILTER_enable_In;
  assign ack = SC_GT_FILTER_ack_In;

  gtState_t               stateQ;
  gtState_t               stateD;
  logic [COUNT_WIDTH-1:0] countQ;
  logic [COUNT_WIDTH-1:0] countD;
  logic                   alarmQ;
  logic                   alarmD;
  logic                   eventInc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      countQ <= '0;
      alarmQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      alarmQ <= alarmD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    alarmD   = alarmQ;
    eventInc = 1'b0;
    unique case (stateQ)
      IDLE: begin
        alarmD = 1'b0;
        if (en && gt) begin
          stateD = QUALIFY;
          countD = COUNT_WIDTH'(1);
        end else begin
          countD = '0;
        end
      end
      QUALIFY: begin
        alarmD = 1'b0;
        if (!en || !gt) begin
          stateD = IDLE;
          countD = '0;
        end else if (countQ == LAST) begin
          // ack is not looked at here: the alarm always latches
          stateD   = ALARM;
          countD   = '0;
          alarmD   = 1'b1;
          eventInc = 1'b1;
        end else begin
          countD = countQ + COUNT_WIDTH'(1);
        end
      end
      ALARM: begin
        countD = '0;
        alarmD = 1'b1;
        if (ack) begin
          alarmD = 1'b0;
          stateD = gt ? RELEASE : IDLE;
        end
      end
      RELEASE: begin
        countD = '0;
        alarmD = 1'b0;
        if (!gt) begin
          stateD = IDLE;
        end
      end
    endcase
  end

  sc_sat_counter #(
    .WIDTH(EVENT_WIDTH)
  ) uEvents (
    .clock(clk),
    .reset(rst),
    .inc  (eventInc),
    .value(SC_GT_FILTER_events_OutBUS)
  );

  assign SC_GT_FILTER_alarm_Out    = alarmQ;
  assign SC_GT_FILTER_count_OutBUS = countQ;
  assign SC_GT_FILTER_state_OutBUS = stateQ;

endmodule
